// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector with run-time pattern/length,
// sticky or pulse detect, overlapping or restarting match, saturating match count.
module seq_detect_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               set_i,
    input  logic               d_i,
    input  logic               d_valid_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               sticky_i,
    input  logic               overlap_i,
    output logic               detect_o,
    output logic [CNT_W-1:0]   match_cnt_o,
    output logic               len_err_o
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;

    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic [MAX_LEN-1:0] len_mask;
    logic               hit;

    always_comb begin
        // NOTE: every always_comb output gets a default before any loop or branch so no latch is inferred.
        len_mask = '0;
        hist_n   = {hist[MAX_LEN-2:0], d_i};
        fill_n   = (fill == MAX_LEN_L) ? fill : fill + 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        // Only the newest len_q history bits take part in the compare.
        hit = !len_err_o && (fill_n >= len_q) && (((hist_n ^ pat_q) & len_mask) == '0);
    end

    // NOTE: all state is written with <= in a single clocked block so every register updates from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist        <= '0;
            fill        <= '0;
            detect_o    <= 1'b0;
            match_cnt_o <= '0;
            len_err_o   <= 1'b0;
            pat_q       <= '0;
            len_q       <= '0;
        end else if (!set_i) begin
            hist        <= '0;
            fill        <= '0;
            detect_o    <= 1'b0;
            match_cnt_o <= '0;
            pat_q       <= pattern_i;
            len_q       <= len_i;
            len_err_o   <= (len_i == '0) || (len_i > MAX_LEN_L);
        end else if (d_valid_i && hit) begin
            detect_o <= 1'b1;
            if (match_cnt_o != '1) begin
                match_cnt_o <= match_cnt_o + 1'b1;
            end
            // Non-overlap restarts the history so the next match needs len_q fresh bits.
            if (overlap_i) begin
                hist <= hist_n;
                fill <= fill_n;
            end else begin
                hist <= '0;
                fill <= '0;
            end
        end else begin
            if (d_valid_i) begin
                hist <= hist_n;
                fill <= fill_n;
            end
            detect_o <= sticky_i & detect_o;
        end
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial bit-pattern detector, the successor to the fixed 5-state Moore detector in the statemachine library.
- Pattern (up to MAX_LEN bits) and its length are run-time configured, latched while the block is disabled.
- Supports sticky or pulse detect output and overlapping or non-overlapping matching.
- Counts matches in a saturating counter.
- Sits on a serial data path behind a bit-valid strobe; detect feeds downstream control logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
CNT_W, 8, width of match counter

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous active-high reset
set_i  input  1  enable; low = synchronous clear of history/detect, config capture
d_i  input  1  serial data bit
d_valid_i  input  1  d_i is sampled only when high
pattern_i  input  MAX_LEN  pattern; bit [len-1] is first-received bit, bit [0] last
len_i  input  $clog2(MAX_LEN+1)  pattern length in bits
sticky_i  input  1  1 = detect_o latches high; 0 = one-cycle pulse per match
overlap_i  input  1  1 = overlapping matches allowed; 0 = history restarts after a match
detect_o  output  1  registered match indication
match_cnt_o  output  CNT_W  saturating count of matches since clear
len_err_o  output  1  latched config invalid (len 0 or > MAX_LEN)

Behaviour:
- Reset (rst_i=1, async): hist=0, fill=0, detect_o=0, match_cnt_o=0, len_err_o=0, pat_q=0, len_q=0.
- Disabled (set_i=0, synchronous):
  - hist=0, fill=0, detect_o=0, match_cnt_o=0.
  - pat_q<=pattern_i, len_q<=len_i.
  - len_err_o <= (len_i==0 || len_i>MAX_LEN).
  - d_i is ignored.
- Enabled (set_i=1):
  - Config registers hold; pattern_i/len_i changes have no effect.
- Bit accept (set_i=1 && d_valid_i=1):
  - hist_n = {hist[MAX_LEN-2:0], d_i}.
  - fill_n = min(fill+1, MAX_LEN).
- Match condition:
  - !len_err_o && fill_n >= len_q && hist_n[len_q-1:0] == pat_q[len_q-1:0].
  - Bits above len_q are ignored.
- On match:
  - match_cnt_o increments, saturating at 2^CNT_W-1.
  - Non-overlap mode: hist<=0, fill<=0, so the next match needs len_q fresh bits.
  - Overlap mode: hist<=hist_n, fill<=fill_n.
- detect_o timing and modes:
  - Registered; goes high on the clock edge that accepts the completing bit, i.e. visible the cycle after d_i/d_valid_i present it (latency 1).
  - Sticky: once high, stays high until set_i=0 or rst_i.
  - Pulse: high for exactly one cycle per match; low in any cycle with no match, including d_valid_i=0 cycles.
- d_valid_i=0 with set_i=1: hist, fill, cnt hold; detect_o holds in sticky mode, 0 in pulse mode.
- sticky_i and overlap_i are sampled every cycle (live). Switching mid-stream takes effect on the next accepted bit; already-set sticky detect_o is not cleared by switching to pulse until the next cycle's evaluation (pulse rule applies then).
- len_err_o=1: detector never matches; counter stays 0.
- Precedence: rst_i > set_i=0 > normal operation.
- Implementation: no combinational path from d_i to outputs; all outputs registered.

Test Plan:
1. MAX_LEN=8, set_i=0 with pattern_i=8'b00011010, len_i=5, sticky=1, overlap=1; set_i=1, feed 1,1,0,1,0 -> detect_o rises one cycle after the 5th bit, stays high through 10 further random bits; match_cnt_o=1 (plus any further matches).
2. Pattern 101, len 3, pulse, overlap=1, feed 1,0,1,0,1 -> detect_o pulses after bits 3 and 5, match_cnt_o=2; repeat with overlap=0 -> single pulse after bit 3, match_cnt_o=1.
3. Same as 2 with d_valid_i deasserted for 3 cycles between bits 2 and 3 -> detection delayed by exactly 3 cycles, no spurious pulses, counts unchanged.
4. CNT_W=2, pattern 1, len 1, overlap, feed 6 ones -> match_cnt_o 1,2,3,3,3,3 (saturates).
5. Feed 1,1,0,1 of pattern 11010, drop set_i for one cycle, then feed 0 -> no detect; hist/fill cleared; full 11010 afterwards detects. Assert rst_i mid-cycle -> all outputs 0 immediately, before the next clock edge.
6. set_i=0 with len_i=0, then len_i=9 -> len_err_o=1 after the capturing edge, no detection on any stream; len_i=8 -> len_err_o=0.
